// File: rtl/ula_sequencer_if.sv
// Command and result streams between a host/control path and ula_sequencer.
// The host side is master; the sequencer side is slave.
interface ula_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int RES_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [OP_W-1:0]   res_op;
  logic              res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_op, res_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_op, res_err
  );
endinterface

// File: rtl/ula_sequencer.sv
// Queues ALU commands, drives one registered ULA, and returns its results in
// order with valid/ready handshaking. Divide by zero is flagged and saturated.
module ula_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int RES_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  ula_sequencer_if.slave    bus,
  output logic [OP_W-1:0]   ula_sel,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  input  logic [RES_W-1:0]  ula_s,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  cmd_t              mem [DEPTH];
  cmd_t              head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic              full, empty, push, pop, hs, rdy_en, div0;
  logic [1:0]        state;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic [OP_W-1:0]   res_op;
  logic              res_err;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];
  // rdy_en keeps cmd_ready low until the first edge after reset release.
  assign bus.cmd_ready = rdy_en & ~full;
  assign push  = bus.cmd_valid & bus.cmd_ready;
  assign hs    = (state == HOLD) & res_valid & bus.res_ready;
  assign pop   = ~empty & ((state == IDLE) | hs);
  // ula_sel/ula_b still hold the issued command while in WAIT.
  assign div0  = (ula_sel == OP_DIV) && (ula_b == '0);
  assign busy  = ~empty | (state != IDLE);

  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_op    = res_op;
  assign bus.res_err   = res_err;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      ula_sel   <= '0;
      ula_a     <= '0;
      ula_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_err   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (pop) begin
        ula_sel <= head.op;
        ula_a   <= head.a;
        ula_b   <= head.b;
      end
      case (state)
        IDLE:  if (pop) state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT: begin
          res_valid <= 1'b1;
          res_op    <= ula_sel;
          res_err   <= div0;
          res_data  <= div0 ? '1 : ula_s;
          state     <= HOLD;
        end
        HOLD: if (hs) begin
          res_valid <= 1'b0;
          state     <= pop ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
